// File: rtl/firc_pkg.sv
// firc_pkg: shared types, widths and the round/saturate helper for the firc output path
package firc_pkg;
  localparam int FIRC_OUT_W = 24;
  localparam int FIRC_FRAC_DROP = 8;
  localparam int FIRC_MAX_W = 64;
  typedef struct packed {
    logic signed [FIRC_OUT_W-1:0] I, Q;
    logic sat;
  } OutSamp;
  // Works at 64 bits so any IN_W up to 63 has headroom for the rounding add; returns {sat, value}.
  function automatic logic [FIRC_MAX_W:0] round_sat(input logic signed [FIRC_MAX_W-1:0] x,
                                                    input int frac, input int out_w);
    logic signed [FIRC_MAX_W-1:0] r, hi, lo;
    r  = (x + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return r > hi ? {1'b1, hi} : r < lo ? {1'b1, lo} : {1'b0, r};
  endfunction
endpackage

// File: rtl/out_fifo_fwft.sv
// out_fifo_fwft: first-word-fall-through FIFO with occupancy and next-occupancy outputs
module out_fifo_fwft #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_nxt_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q, count_d;
  always_comb count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(push_i);
      rptr_q  <= rptr_q + AW'(pop_i);
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wptr_q] <= wdata_i;
  assign rdata_o     = mem_q[rptr_q];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;
  assign full_o      = count_q == (AW+1)'(DEPTH);
  assign empty_o     = count_q == '0;
endmodule

// File: rtl/firc_out_buffer.sv
// firc_out_buffer: round/saturate firc I/Q results and buffer them behind a valid/ready sink port
module firc_out_buffer
  import firc_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int OUT_W     = FIRC_OUT_W,
  parameter int FRAC_DROP = FIRC_FRAC_DROP,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic                        PushIn,
  input  logic signed [IN_W-1:0]      FI,
  input  logic signed [IN_W-1:0]      FQ,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic signed [OUT_W-1:0]     OutI,
  output logic signed [OUT_W-1:0]     OutQ,
  output logic                        OutSat,
  output logic                        AlmostFull,
  output logic [$clog2(DEPTH):0]      Count,
  output logic                        Overflow,
  input  logic                        ClrOvf
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = 2 * OUT_W + 1;
  logic [FIRC_MAX_W:0] ri, rq;
  logic [DW-1:0] s1_d, s1_q, rdata, rd;
  logic s1_v_q, ovf_q, ovf_d, afull_q, push, pop, drop, full, empty, unused_hi;
  logic [CW-1:0] cnt, cnt_nxt;
  assign ri   = round_sat(FIRC_MAX_W'(FI), FRAC_DROP, OUT_W);
  assign rq   = round_sat(FIRC_MAX_W'(FQ), FRAC_DROP, OUT_W);
  assign s1_d = {ri[OUT_W-1:0], rq[OUT_W-1:0], ri[FIRC_MAX_W] | rq[FIRC_MAX_W]};
  assign unused_hi = ^{ri[FIRC_MAX_W-1:OUT_W], rq[FIRC_MAX_W-1:OUT_W]};
  // A full FIFO still accepts the stage-1 sample when the sink drains one in the same cycle.
  always_comb begin
    pop   = ~empty & OutReady;
    push  = s1_v_q & (~full | pop);
    drop  = s1_v_q & full & ~pop;
    ovf_d = drop | (ovf_q & ~ClrOvf);
  end
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      s1_v_q  <= 1'b0;
      s1_q    <= '0;
      ovf_q   <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      s1_v_q  <= PushIn;
      s1_q    <= PushIn ? s1_d : s1_q;
      ovf_q   <= ovf_d;
      afull_q <= cnt_nxt >= CW'(AFULL_LVL);
    end
  out_fifo_fwft #(.WIDTH(DW), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .Reset      (Reset),
    .push_i     (push),
    .pop_i      (pop),
    .wdata_i    (s1_q),
    .rdata_o    (rdata),
    .count_o    (cnt),
    .count_nxt_o(cnt_nxt),
    .full_o     (full),
    .empty_o    (empty)
  );
  assign rd         = empty ? '0 : rdata;
  assign OutValid   = ~empty;
  assign OutI       = rd[DW-1 -: OUT_W];
  assign OutQ       = rd[OUT_W:1];
  assign OutSat     = rd[0];
  assign AlmostFull = afull_q;
  assign Count      = cnt;
  assign Overflow   = ovf_q;
endmodule
